// File: rtl/game_flow_ctrl_if.sv
// Game-flow bus: button/collision inputs into the sequencer and the
// gs/halt/score/high-score/speed outputs consumed by the VGA-side blocks.
// master = game_flow_ctrl, slave = the consumer side (buttons in, state out).
interface game_flow_ctrl_if;
  logic        btn_start;
  logic        collision;
  logic        btn_pause;
  logic [1:0]  gs;
  logic        halt;
  logic        paused;
  logic [15:0] score_bcd;
  logic [15:0] hi_bcd;
  logic [2:0]  speed_level;
  logic        new_hi;

  modport master (
    input  btn_start, collision, btn_pause,
    output gs, halt, paused, score_bcd, hi_bcd, speed_level, new_hi
  );

  modport slave (
    output btn_start, collision, btn_pause,
    input  gs, halt, paused, score_bcd, hi_bcd, speed_level, new_hi
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Dino game flow sequencer: IDLE/RUN/OVER (and PAUSE when GAME_PAUSE_EN is
// defined). Owns the BCD score, high score and speed level; all outputs are
// registered on the single pixel clock.
module game_flow_ctrl #(
  parameter int TICK_DIV  = 2517500,
  parameter int OVER_HOLD = 12587500,
  parameter int MAX_LEVEL = 7
) (
  input  logic             clk,
  input  logic             reset,
  game_flow_ctrl_if.master bus
);
  localparam int PRE_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int HOLD_W = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(OVER_HOLD - 1);
  localparam logic [2:0]        LVL_MAX   = 3'(MAX_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_OVER  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PRE_W-1:0]   r_pre, w_pre_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic [15:0]        r_score, w_score_nxt;
  logic [15:0]        r_hi, w_hi_nxt;
  logic               r_new_hi, w_new_hi_nxt;
  logic               r_halt;
  logic [1:0]         r_gs;
  logic [2:0]         r_level;
  logic               r_start_prev, r_start_arm;
  logic               w_start_edge, w_tick;

  // Ripple-carry BCD increment over the four digits
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          res[i*4 +: 4] = 4'd0;
        end else begin
          res[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Any thousands digit saturates the level, otherwise hundreds capped at max
  function automatic logic [2:0] level_of(input logic [15:0] s);
    if (s[15:12] != 4'd0)           return LVL_MAX;
    if (s[11:8] > 4'(MAX_LEVEL))    return LVL_MAX;
    return s[10:8];
  endfunction

  assign w_tick = (r_pre == PRE_LAST);

  // Rising-edge detect; arm is loaded during reset so a button held across
  // reset release must be let go before it can start a run
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_start_prev <= 1'b0;
      r_start_arm  <= !bus.btn_start;
    end else begin
      r_start_prev <= bus.btn_start;
      r_start_arm  <= r_start_arm | !bus.btn_start;
    end
  end
  assign w_start_edge = bus.btn_start & !r_start_prev & r_start_arm;

`ifdef GAME_PAUSE_EN
  logic r_pause_prev, r_pause_arm, w_pause_edge, r_paused;

  // Pause button edge detect, same arming rule as start
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pause_prev <= 1'b0;
      r_pause_arm  <= !bus.btn_pause;
      r_paused     <= 1'b0;
    end else begin
      r_pause_prev <= bus.btn_pause;
      r_pause_arm  <= r_pause_arm | !bus.btn_pause;
      r_paused     <= (w_state_nxt == S_PAUSE);
    end
  end
  assign w_pause_edge = bus.btn_pause & !r_pause_prev & r_pause_arm;
  assign bus.paused   = r_paused;
`else
  logic w_unused_pause;
  assign w_unused_pause = bus.btn_pause;
  assign bus.paused     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; collision has priority over pause in RUN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start_edge) w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.collision) w_state_nxt = S_OVER;
`ifdef GAME_PAUSE_EN
        else if (w_pause_edge) w_state_nxt = S_PAUSE;
`endif
      end
      S_OVER: if (w_start_edge && (r_hold == HOLD_LAST)) w_state_nxt = S_RUN;
`ifdef GAME_PAUSE_EN
      S_PAUSE: if (w_pause_edge) w_state_nxt = S_RUN;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath next values: prescaler, score, hold timer, high score
  always_comb begin
    w_pre_nxt    = r_pre;
    w_hold_nxt   = r_hold;
    w_score_nxt  = r_score;
    w_hi_nxt     = r_hi;
    w_new_hi_nxt = r_new_hi;
    case (r_state)
      S_IDLE: begin
        w_pre_nxt   = '0;
        w_score_nxt = '0;
        if (w_start_edge) w_new_hi_nxt = 1'b0;
      end
      S_RUN: begin
        if (w_state_nxt == S_OVER) begin
          w_hold_nxt = '0;
        end else if (w_state_nxt == S_RUN) begin
          if (w_tick) begin
            w_pre_nxt = '0;
            if (r_score != 16'h9999) w_score_nxt = bcd_inc(r_score);
          end else begin
            w_pre_nxt = r_pre + 1'b1;
          end
        end
      end
      S_OVER: begin
        // Hold is zero only on the first OVER cycle; score is frozen here
        if ((r_hold == '0) && (r_score > r_hi)) begin
          w_hi_nxt     = r_score;
          w_new_hi_nxt = 1'b1;
        end
        if (r_hold != HOLD_LAST) w_hold_nxt = r_hold + 1'b1;
        if (w_state_nxt == S_RUN) begin
          w_pre_nxt    = '0;
          w_score_nxt  = '0;
          w_new_hi_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pre    <= '0;
      r_hold   <= '0;
      r_score  <= '0;
      r_hi     <= '0;
      r_new_hi <= 1'b0;
      r_halt   <= 1'b0;
      r_gs     <= 2'd0;
      r_level  <= 3'd0;
    end else begin
      r_pre    <= w_pre_nxt;
      r_hold   <= w_hold_nxt;
      r_score  <= w_score_nxt;
      r_hi     <= w_hi_nxt;
      r_new_hi <= w_new_hi_nxt;
      r_halt   <= (w_score_nxt == 16'h9999);
      r_level  <= level_of(r_score);
      case (w_state_nxt)
        S_IDLE:  r_gs <= 2'd0;
        S_RUN:   r_gs <= 2'd1;
        default: r_gs <= 2'd2;
      endcase
    end
  end

  assign bus.gs          = r_gs;
  assign bus.halt        = r_halt;
  assign bus.score_bcd   = r_score;
  assign bus.hi_bcd      = r_hi;
  assign bus.speed_level = r_level;
  assign bus.new_hi      = r_new_hi;
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Central game-state sequencer for the dino game. It drives the gs/halt pair consumed by the score renderer and obstacle and sprite blocks, and owns the authoritative 4-digit BCD score, high score and speed level. Score digits are exported for display instead of being counted inside the renderer. It sits between the button/collision inputs and all VGA-side drawing blocks, all on the single 25 MHz pixel clock.

Parameters:
TICK_DIV, 2517500, clk cycles per score point (about 10 points/s at 25.175 MHz); counter width is $clog2(TICK_DIV).
OVER_HOLD, 12587500, minimum cycles spent in OVER before a restart press is accepted (about 0.5 s).
MAX_LEVEL, 7, saturation value of speed_level; must be 7 or less.

Ports:
clk  in  1  pixel clock, single clock domain
reset  in  1  synchronous, active-low reset; sampled on posedge clk
btn_start  in  1  jump/start button, already synchronised and debounced, level
collision  in  1  dino/obstacle overlap flag, level, from the sprite compositor
btn_pause  in  1  pause button, level; used only with GAME_PAUSE_EN
gs  out  2  game state: 0 = IDLE, 1 = RUN, 2 = OVER/frozen
halt  out  1  score saturated at 9999
paused  out  1  high while in PAUSE state (always 0 without GAME_PAUSE_EN)
score_bcd  out  16  {thousands, hundreds, tens, units}, 4 bits each
hi_bcd  out  16  high score, same packing
speed_level  out  3  obstacle speed index, 0..MAX_LEVEL
new_hi  out  1  high score was beaten in the current/last run

Behaviour:
- Reset (reset==0 at a clk edge): gs=0, state IDLE, halt=0, paused=0, score_bcd=0, hi_bcd=0, speed_level=0, new_hi=0, prescaler and hold counters cleared. Reset mid-run also clears the high score.
- All outputs are registered. A state change is visible on gs one cycle after the clk edge that samples the trigger.
- Button events: rising edge only, detected against the previous-cycle sample (prev register cleared by reset). A held button never re-triggers.
- IDLE (gs=0):
  - Score and prescaler held at 0.
  - btn_start edge -> RUN. Clear new_hi.
- RUN (gs=1):
  - The prescaler increments each cycle. When it reaches TICK_DIV-1 it wraps to 0 and the score increments by 1 in BCD with ripple carry (0099 -> 0100, 0999 -> 1000).
  - At 9999 the score stays at 9999, halt=1, and the prescaler keeps running without effect.
  - collision==1 -> OVER. If collision and a score tick land on the same cycle, collision wins and there is no increment.
- OVER (gs=2):
  - Score frozen. Hold counter starts at 0 on entry.
  - On the entry cycle, if score_bcd > hi_bcd (unsigned compare on the packed value is valid for BCD), hi_bcd <= score_bcd and new_hi <= 1, both visible one cycle after gs becomes 2. Equal score does not update.
  - btn_start edge while the hold counter is below OVER_HOLD-1 is ignored.
  - After the hold expires, a btn_start edge -> RUN with score, prescaler and halt cleared in the same transition and new_hi cleared. hi_bcd is kept.
  - collision is ignored in OVER.
- speed_level:
  - MAX_LEVEL if the thousands digit is nonzero; otherwise min(hundreds digit, MAX_LEVEL).
  - Registered; updates one cycle after score_bcd.
- Undefined state encodings recover to IDLE.

Optional Feature:
GAME_PAUSE_EN
- Defined:
  - PAUSE state exists. A btn_pause edge in RUN -> PAUSE: gs=2, paused=1, prescaler and score frozen (the prescaler value is retained).
  - A btn_pause edge in PAUSE -> RUN, resuming the prescaler from its retained value. collision and btn_start are ignored in PAUSE.
  - A btn_pause edge in the same cycle as collision in RUN: collision wins -> OVER.
- Undefined: btn_pause is ignored, paused is tied to 0, and no PAUSE state logic is generated.

Test Plan (TICK_DIV=4, OVER_HOLD=8):
- Reset low 2 cycles, then start edge -> gs=1 the next cycle; after 40 cycles score_bcd=16'h0010 and speed_level=0.
- Preload 0099 by running 396 cycles, then one more tick -> 16'h0100, speed_level=1 the cycle after. Run to 9999 -> halt=1, and the score stays 9999 over 20 more cycles.
- Collision asserted on the same cycle the prescaler hits 3 -> gs=2, no increment. hi_bcd equals the final score and new_hi=1 one cycle later. A second run ending at a lower score leaves hi_bcd unchanged and new_hi=0.
- In OVER, start edge at hold count 3 -> ignored (gs stays 2). Start edge after 8 cycles -> gs=1, score_bcd=0, hi_bcd retained.
- Reset asserted mid-RUN with score 0042 and hi 0100 -> next cycle all outputs 0, gs=0. A held btn_start across reset release gives no RUN until it is released and pressed again.
- GAME_PAUSE_EN: pause at score 0005 for 100 cycles -> score stays 0005 and paused=1. Unpause -> the next increment arrives after the remaining prescaler cycles, not a full TICK_DIV.
